// File: rtl/id_char_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : id_char_gen_if
// Description : Handshake bundle between a start/control master, the
//               identifier character generator and the character consumer.
//               Control side : start, letter, digit0, ndigits
//               Char side    : char_data, char_valid, ready
//               Status       : busy, done
//               master modport drives control/ready and observes outputs;
//               slave modport is the generator's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_char_gen_if #(
  parameter int LEN_W = 4
);
  logic             start;
  logic [7:0]       letter;
  logic [3:0]       digit0;
  logic [LEN_W-1:0] ndigits;
  logic             ready;
  logic [7:0]       char_data;
  logic             char_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, letter, digit0, ndigits, ready,
    input  char_data, char_valid, busy, done
  );

  modport slave (
    input  start, letter, digit0, ndigits, ready,
    output char_data, char_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/id_char_gen.sv
`default_nettype none
// ============================================================================
// Module      : id_char_gen
// Description : Emits an ASCII identifier, one char per accepted handshake:
//               one letter followed by ndigits decimal digits counting up
//               mod 10 from digit0. Optional trailing space when the macro
//               ID_GEN_SEP_EN is defined.
// Ports       : clk   - clock, all logic on posedge
//               reset - synchronous, active-high
//               bus   - id_char_gen_if.slave (start/letter/digit0/ndigits/
//                       ready in; char_data/char_valid/busy/done out)
// Config      : ID_GEN_SEP_EN - append ASCII space (8'h20) after last char
// Revision    : 1.0 - initial release
// ============================================================================
module id_char_gen #(
  parameter int LEN_W = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  id_char_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LETTER = 3'd1,
    S_DIGITS = 3'd2,
`ifdef ID_GEN_SEP_EN
    S_SEP    = 3'd3,
`endif
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  logic [3:0]       r_digit;    // digit currently offered (or next to offer)
  logic [LEN_W-1:0] r_remain;   // digits not yet accepted
  logic [7:0]       r_char;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_letter_ok;
  logic [7:0]       w_letter_clean;
  logic [3:0]       w_digit_clean;
  logic [3:0]       w_next_digit;
  logic             w_more_digits;
  logic [7:0]       w_digit_char;

  assign w_letter_ok    = ((bus.letter >= 8'h41) && (bus.letter <= 8'h5A)) ||
                          ((bus.letter >= 8'h61) && (bus.letter <= 8'h7A));
  assign w_letter_clean = w_letter_ok ? bus.letter : 8'h61;
  assign w_digit_clean  = (bus.digit0 > 4'd9) ? 4'd0 : bus.digit0;
  assign w_next_digit   = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;

  // Whether another digit follows the char being accepted, and its ASCII.
  // From LETTER the first digit is r_digit itself; from DIGITS it is the
  // incremented value and the accepted digit is the last when one remains.
  assign w_more_digits  = (r_state == S_LETTER) ? (r_remain != '0)
                                                : (r_remain != LEN_W'(1));
  assign w_digit_char   = 8'h30 + {4'd0, (r_state == S_LETTER) ? r_digit
                                                                 : w_next_digit};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_digit  <= 4'd0;
      r_remain <= '0;
      r_char   <= 8'h00;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_digit  <= w_digit_clean;
            r_remain <= bus.ndigits;
            r_char   <= w_letter_clean;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_LETTER;
          end
        end

        S_LETTER, S_DIGITS: begin
          if (bus.ready) begin
            if (r_state == S_DIGITS) begin
              r_digit  <= w_next_digit;
              r_remain <= r_remain - LEN_W'(1);
            end
            if (w_more_digits) begin
              r_char  <= w_digit_char;
              r_state <= S_DIGITS;
            end else begin
`ifdef ID_GEN_SEP_EN
              r_char  <= 8'h20;
              r_state <= S_SEP;
`else
              r_char  <= 8'h00;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end
          end
        end

`ifdef ID_GEN_SEP_EN
        S_SEP: begin
          if (bus.ready) begin
            r_char  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          // start is deliberately ignored here
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_char  <= 8'h00;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.char_data  = r_char;
  assign bus.char_valid = r_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
`default_nettype wire
